// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM encodings, parameter defaults
// and a small address helper.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          TIMEOUT_CYCLES_DEF = 16;
    localparam logic [31:0] ERR_RDATA_DEF      = 32'hDEADBEEF;

    function automatic logic misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// One-entry posted write buffer for dmem_bridge. The module only exists in builds
// with DMEM_BRIDGE_WBUF_EN defined, which is the only configuration that instantiates it.
`ifdef DMEM_BRIDGE_WBUF_EN
module dmem_wbuf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    input  logic        drain_done,
    output logic        valid,
    output logic [31:0] addr,
    output logic [31:0] data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            addr  <= 32'h0;
            data  <= 32'h0;
        end else if (load) begin
            valid <= 1'b1;
            addr  <= load_addr;
            data  <= load_data;
        end else if (drain_done) begin
            valid <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/dmem_bridge.sv
// MEM-stage to req/ack bus bridge with pipeline stall and sticky error flags.
// Define DMEM_BRIDGE_WBUF_EN to add a one-entry posted write buffer.
//
//  state | meaning
//  IDLE  | waiting for a MEM-stage access (or a buffered store to drain)
//  REQ   | bus_req asserted, waiting for bus_ack or timeout
//  DONE  | one-cycle release so the pipeline advances and WB captures core_rdata
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_memread,
    input  logic        core_memwrite,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        err_misalign,
    output logic        err_timeout,
    input  logic        err_clear
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   rdata_q;
    logic          drain_q;

    logic          access, is_write, misal;
    logic          stall_c, misal_evt, ack_evt, tmo_evt;
    logic          issue, issue_we, issue_drain;
    logic [31:0]   issue_addr, issue_wdata;

    assign is_write = core_memwrite;
    assign access   = core_memread | core_memwrite;
    assign misal    = access & misaligned(core_addr[1:0]);

`ifdef DMEM_BRIDGE_WBUF_EN
    logic        wb_load, wb_valid, wb_done;
    logic [31:0] wb_addr, wb_data;

    assign wb_done = drain_q & (ack_evt | tmo_evt);

    dmem_wbuf u_wbuf (
        .clk        (clk),
        .reset      (reset),
        .load       (wb_load),
        .load_addr  (core_addr),
        .load_data  (core_wdata),
        .drain_done (wb_done),
        .valid      (wb_valid),
        .addr       (wb_addr),
        .data       (wb_data)
    );
`endif

    always_comb begin
        state_nxt   = state;
        stall_c     = 1'b0;
        issue       = 1'b0;
        issue_we    = is_write;
        issue_addr  = core_addr;
        issue_wdata = core_wdata;
        issue_drain = 1'b0;
        misal_evt   = 1'b0;
        ack_evt     = 1'b0;
        tmo_evt     = 1'b0;
`ifdef DMEM_BRIDGE_WBUF_EN
        wb_load     = 1'b0;
`endif
        case (state)
            IDLE: begin
                misal_evt = misal;
`ifdef DMEM_BRIDGE_WBUF_EN
                // A pending buffered store always goes out first; core accesses wait behind it.
                if (wb_valid) begin
                    issue       = 1'b1;
                    issue_drain = 1'b1;
                    issue_we    = 1'b1;
                    issue_addr  = wb_addr;
                    issue_wdata = wb_data;
                    stall_c     = access & ~misal;
                end else if (access && !misal && is_write) begin
                    wb_load = 1'b1;
                end else if (access && !misal) begin
                    issue   = 1'b1;
                    stall_c = 1'b1;
                end
`else
                if (access && !misal) begin
                    issue   = 1'b1;
                    stall_c = 1'b1;
                end
`endif
                if (issue) state_nxt = REQ;
            end
            REQ: begin
                stall_c = 1'b1;
                // A drain runs behind a free-running pipeline, so core accesses are judged live.
                if (drain_q) begin
                    stall_c   = access & ~misal;
                    misal_evt = misal;
                end
                if (bus_ack) begin
                    ack_evt   = 1'b1;
                    state_nxt = drain_q ? IDLE : DONE;
                end else if (cnt == CNT_LAST) begin
                    tmo_evt   = 1'b1;
                    state_nxt = drain_q ? IDLE : DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign core_stall = stall_c & ~reset;
    assign core_rdata = (misal_evt && !reset) ? ERR_RDATA : rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            rdata_q      <= 32'h0;
            drain_q      <= 1'b0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'h0;
            bus_wdata    <= 32'h0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                bus_req   <= 1'b1;
                bus_we    <= issue_we;
                bus_addr  <= {issue_addr[31:2], 2'b00};
                bus_wdata <= issue_wdata;
                drain_q   <= issue_drain;
                cnt       <= '0;
            end else if (state == REQ) begin
                if (ack_evt || tmo_evt) bus_req <= 1'b0;
                else                    cnt     <= cnt + 1'b1;
            end
            if (ack_evt && !bus_we)    rdata_q <= bus_rdata;
            if (tmo_evt && !drain_q)   rdata_q <= ERR_RDATA;
            if (misal_evt)             rdata_q <= ERR_RDATA;
            err_misalign <= misal_evt | (err_misalign & ~err_clear);
            err_timeout  <= tmo_evt   | (err_timeout  & ~err_clear);
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: scoreboarded load/store, error, timeout and reset scenarios.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_memread, core_memwrite;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        core_stall;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        err_misalign, err_timeout, err_clear;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          reqs;
        int          stalls;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          reqs;
        int          stalls;
        bit          stable;
        bit          done;
    } obs_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    dmem_bridge dut (
        .clk           (clk),
        .reset         (reset),
        .core_memread  (core_memread),
        .core_memwrite (core_memwrite),
        .core_addr     (core_addr),
        .core_wdata    (core_wdata),
        .core_rdata    (core_rdata),
        .core_stall    (core_stall),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_ack       (bus_ack),
        .bus_rdata     (bus_rdata),
        .err_misalign  (err_misalign),
        .err_timeout   (err_timeout),
        .err_clear     (err_clear)
    );

    task automatic drive_idle();
        @(posedge clk); #1;
        core_memread = 1'b0; core_memwrite = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
        err_clear = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    endtask

    // Presents one access and plays a slave that acks on request cycle ack_delay+1 (never if <0).
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int ack_delay, input logic [31:0] ack_data, output obs_t o);
        o = '{default: '0};
        o.stable = 1'b1;
        @(posedge clk); #1;
        core_memread = ~we; core_memwrite = we; core_addr = addr; core_wdata = wdata;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus_req) begin
                if (o.reqs == 0) begin
                    o.we = bus_we; o.addr = bus_addr; o.wdata = bus_wdata;
                end else if (bus_we !== o.we || bus_addr !== o.addr || bus_wdata !== o.wdata) begin
                    o.stable = 1'b0;
                end
                o.reqs++;
                if (o.reqs == ack_delay + 1) begin
                    bus_ack = 1'b1; bus_rdata = ack_data;
                end
            end
            if (!core_stall) begin
                o.done = 1'b1; o.rdata = core_rdata;
                break;
            end
            o.stalls++;
            @(posedge clk); #1;
            bus_ack = 1'b0; bus_rdata = 32'h0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        core_memread = 1'b0; core_memwrite = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0; err_clear = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (core_rdata !== 32'h0) begin failures++; $display("FAIL reset_core_rdata got=%h exp=0", core_rdata); end
        checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL reset_core_stall got=%b exp=0", core_stall); end
        checks++; if (bus_req !== 1'b0 || bus_we !== 1'b0) begin failures++; $display("FAIL reset_bus_ctl got=%b%b exp=00", bus_req, bus_we); end
        checks++; if (bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin failures++; $display("FAIL reset_bus_data got=%h/%h exp=0/0", bus_addr, bus_wdata); end
        checks++; if (err_misalign !== 1'b0 || err_timeout !== 1'b0) begin failures++; $display("FAIL reset_errs got=%b%b exp=00", err_misalign, err_timeout); end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (core_stall !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b%b exp=00", core_stall, bus_req); end
    endtask

    task automatic test_load();
        obs_t o; exp_t e;
        exp_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, rdata: 32'h12345678, reqs: 1, stalls: 2});
        do_access(1'b0, 32'h100, 32'h0, 0, 32'h12345678, o);
        e = exp_q.pop_front();
        checks++; if (!o.done) begin failures++; $display("FAIL load_done got=0 exp=1"); end
        checks++; if (o.we !== e.we) begin failures++; $display("FAIL load_bus_we got=%b exp=%b", o.we, e.we); end
        checks++; if (o.addr !== e.addr) begin failures++; $display("FAIL load_bus_addr got=%h exp=%h", o.addr, e.addr); end
        checks++; if (o.rdata !== e.rdata) begin failures++; $display("FAIL load_rdata got=%h exp=%h", o.rdata, e.rdata); end
        checks++; if (o.stalls != e.stalls) begin failures++; $display("FAIL load_stalls got=%0d exp=%0d", o.stalls, e.stalls); end
        checks++; if (o.reqs != e.reqs) begin failures++; $display("FAIL load_reqs got=%0d exp=%0d", o.reqs, e.reqs); end
        drive_idle();
    endtask

    task automatic test_ack_idle();
        @(posedge clk); #1 bus_ack = 1'b1; bus_rdata = 32'hFFFF0000;
        @(negedge clk);
        checks++; if (core_stall !== 1'b0 || bus_req !== 1'b0) begin failures++; $display("FAIL ack_idle_ctl got=%b%b exp=00", core_stall, bus_req); end
        @(posedge clk); #1 bus_ack = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        checks++; if (core_rdata !== 32'h12345678) begin failures++; $display("FAIL ack_idle_rdata got=%h exp=12345678", core_rdata); end
        checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL ack_idle_req got=%b exp=0", bus_req); end
    endtask

    task automatic test_store();
        obs_t o; exp_t e;
        exp_q.push_back('{we: 1'b1, addr: 32'h204, wdata: 32'hCAFEF00D, rdata: 32'h12345678, reqs: 6, stalls: 7});
        do_access(1'b1, 32'h204, 32'hCAFEF00D, 5, 32'hFFFFFFFF, o);
        e = exp_q.pop_front();
        checks++; if (!o.done) begin failures++; $display("FAIL store_done got=0 exp=1"); end
        checks++; if (o.we !== e.we) begin failures++; $display("FAIL store_bus_we got=%b exp=%b", o.we, e.we); end
        checks++; if (o.addr !== e.addr || o.wdata !== e.wdata) begin failures++; $display("FAIL store_bus got=%h/%h exp=%h/%h", o.addr, o.wdata, e.addr, e.wdata); end
        checks++; if (!o.stable) begin failures++; $display("FAIL store_stable got=0 exp=1"); end
        checks++; if (o.reqs != e.reqs) begin failures++; $display("FAIL store_reqs got=%0d exp=%0d", o.reqs, e.reqs); end
        checks++; if (o.stalls != e.stalls) begin failures++; $display("FAIL store_stalls got=%0d exp=%0d", o.stalls, e.stalls); end
        checks++; if (o.rdata !== e.rdata) begin failures++; $display("FAIL store_rdata_kept got=%h exp=%h", o.rdata, e.rdata); end
        drive_idle();
    endtask

    task automatic test_misalign();
        obs_t o;
        do_access(1'b0, 32'h101, 32'h0, -1, 32'h0, o);
        checks++; if (!o.done || o.stalls != 0 || o.reqs != 0) begin failures++; $display("FAIL misalign_nobus got=%0d/%0d/%0d exp=1/0/0", o.done, o.stalls, o.reqs); end
        checks++; if (o.rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL misalign_rdata got=%h exp=deadbeef", o.rdata); end
        drive_idle();
        @(negedge clk);
        checks++; if (err_misalign !== 1'b1) begin failures++; $display("FAIL misalign_flag got=%b exp=1", err_misalign); end
        do_access(1'b1, 32'h206, 32'h55555555, 0, 32'h0, o);
        checks++; if (!o.done || o.reqs != 0) begin failures++; $display("FAIL misalign_store_dropped got=%0d/%0d exp=1/0", o.done, o.reqs); end
        drive_idle();
        repeat (2) @(negedge clk);
        checks++; if (err_misalign !== 1'b1 || bus_req !== 1'b0) begin failures++; $display("FAIL misalign_sticky got=%b%b exp=10", err_misalign, bus_req); end
        @(posedge clk); #1 err_clear = 1'b1;
        @(posedge clk); #1 err_clear = 1'b0;
        @(negedge clk);
        checks++; if (err_misalign !== 1'b0) begin failures++; $display("FAIL misalign_clear got=%b exp=0", err_misalign); end
        @(posedge clk); #1 err_clear = 1'b1; core_memread = 1'b1; core_addr = 32'h103;
        drive_idle();
        @(negedge clk);
        checks++; if (err_misalign !== 1'b1) begin failures++; $display("FAIL misalign_set_wins got=%b exp=1", err_misalign); end
        @(posedge clk); #1 err_clear = 1'b1;
        drive_idle();
    endtask

    task automatic test_timeout();
        obs_t o; exp_t e;
        exp_q.push_back('{we: 1'b0, addr: 32'h10C, wdata: 32'h0, rdata: 32'hDEADBEEF, reqs: 16, stalls: 17});
        do_access(1'b0, 32'h10C, 32'h0, -1, 32'h0, o);
        e = exp_q.pop_front();
        checks++; if (!o.done) begin failures++; $display("FAIL timeout_done got=0 exp=1"); end
        checks++; if (o.reqs != e.reqs) begin failures++; $display("FAIL timeout_reqs got=%0d exp=%0d", o.reqs, e.reqs); end
        checks++; if (o.stalls != e.stalls) begin failures++; $display("FAIL timeout_stalls got=%0d exp=%0d", o.stalls, e.stalls); end
        checks++; if (o.rdata !== e.rdata) begin failures++; $display("FAIL timeout_rdata got=%h exp=%h", o.rdata, e.rdata); end
        checks++; if (err_timeout !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%b exp=1", err_timeout); end
        drive_idle();
        @(posedge clk); #1 err_clear = 1'b1;
        drive_idle();
        @(negedge clk);
        checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL timeout_clear got=%b exp=0", err_timeout); end
    endtask

    task automatic test_back_to_back();
        obs_t o; exp_t e;
        exp_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0, rdata: 32'hA5A50001, reqs: 2, stalls: 3});
        exp_q.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0, rdata: 32'h5A5A0002, reqs: 2, stalls: 3});
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            do_access(1'b0, e.addr, 32'h0, 1, e.rdata, o);
            checks++; if (o.addr !== e.addr) begin failures++; $display("FAIL b2b_addr%0d got=%h exp=%h", k, o.addr, e.addr); end
            checks++; if (o.rdata !== e.rdata) begin failures++; $display("FAIL b2b_rdata%0d got=%h exp=%h", k, o.rdata, e.rdata); end
            checks++; if (o.stalls != e.stalls || o.reqs != e.reqs) begin failures++; $display("FAIL b2b_timing%0d got=%0d/%0d exp=%0d/%0d", k, o.stalls, o.reqs, e.stalls, e.reqs); end
        end
        drive_idle();
    endtask

    task automatic test_reset_mid();
        obs_t o; int n = 0;
        exp_q.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'h0, rdata: 32'h0, reqs: 0, stalls: 0});
        @(posedge clk); #1 core_memread = 1'b1; core_addr = 32'h80;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk);
            if (bus_req) n++;
        end
        checks++; if (n != 3) begin failures++; $display("FAIL reset_mid_reach got=%0d exp=3", n); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus_req !== 1'b0 || core_stall !== 1'b0) begin failures++; $display("FAIL reset_mid_async got=%b%b exp=00", bus_req, core_stall); end
        exp_q.delete();
        drive_idle();
        @(posedge clk); #1 reset = 1'b0;
        exp_q.push_back('{we: 1'b0, addr: 32'h88, wdata: 32'h0, rdata: 32'h0BADF00D, reqs: 3, stalls: 4});
        do_access(1'b0, 32'h88, 32'h0, 2, 32'h0BADF00D, o);
        begin
            exp_t e;
            e = exp_q.pop_front();
            checks++; if (o.addr !== e.addr || o.we !== e.we) begin failures++; $display("FAIL reset_mid_next_bus got=%h/%b exp=%h/%b", o.addr, o.we, e.addr, e.we); end
            checks++; if (o.rdata !== e.rdata) begin failures++; $display("FAIL reset_mid_next_rdata got=%h exp=%h", o.rdata, e.rdata); end
            checks++; if (o.stalls != e.stalls || o.reqs != e.reqs) begin failures++; $display("FAIL reset_mid_next_timing got=%0d/%0d exp=%0d/%0d", o.stalls, o.reqs, e.stalls, e.reqs); end
        end
        drive_idle();
    endtask

`ifdef DMEM_BRIDGE_WBUF_EN
    task automatic test_wbuf();
        exp_t e; int req_run = 0; int n_tx = 0; int stalls = 0; bit done = 1'b0;
        logic [31:0] rd_exp = 32'h55AA55AA;
        @(posedge clk); #1 core_memwrite = 1'b1; core_memread = 1'b0; core_addr = 32'h300; core_wdata = 32'h11112222;
        exp_q.push_back('{we: 1'b1, addr: 32'h300, wdata: 32'h11112222, rdata: 32'h0, reqs: 2, stalls: 0});
        @(negedge clk);
        checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL wbuf_store_nostall got=%b exp=0", core_stall); end
        @(posedge clk); #1 core_memwrite = 1'b0; core_memread = 1'b1; core_addr = 32'h404; core_wdata = 32'h0;
        exp_q.push_back('{we: 1'b0, addr: 32'h404, wdata: 32'h0, rdata: rd_exp, reqs: 2, stalls: 0});
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus_req) begin
                if (req_run == 0) begin
                    n_tx++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++; $display("FAIL wbuf_extra_tx got=%h exp=none", bus_addr);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus_we !== e.we || bus_addr !== e.addr || (e.we && bus_wdata !== e.wdata)) begin
                            failures++; $display("FAIL wbuf_tx%0d got=%b/%h/%h exp=%b/%h/%h", n_tx, bus_we, bus_addr, bus_wdata, e.we, e.addr, e.wdata);
                        end
                        bus_rdata = e.rdata;
                    end
                end
                req_run++;
                if (req_run == 2) begin bus_ack = 1'b1; req_run = 0; end
            end
            if (!core_stall) begin
                done = 1'b1;
                checks++; if (core_rdata !== rd_exp) begin failures++; $display("FAIL wbuf_load_rdata got=%h exp=%h", core_rdata, rd_exp); end
            end else begin
                stalls++;
                @(posedge clk); #1 bus_ack = 1'b0;
            end
        end
        checks++; if (!done || n_tx != 2) begin failures++; $display("FAIL wbuf_order got=%0d/%0d exp=1/2", done, n_tx); end
        checks++; if (stalls < 4) begin failures++; $display("FAIL wbuf_load_stall got=%0d exp>=4", stalls); end
        drive_idle();
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_ack_idle();
`ifndef DMEM_BRIDGE_WBUF_EN
        test_store();
`endif
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
`ifdef DMEM_BRIDGE_WBUF_EN
        test_wbuf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory interface sitting directly downstream of the pipelined core's MEM stage.
- Converts the core's single-cycle memaddr/memwritedata/memwrite (plus a read strobe derived from memtoreg) into a req/ack bus transaction with arbitrary wait states.
- Returns read data to the MEM/WB register, and drives a stall back to the pipeline while a transaction is outstanding.
- Bus errors (misalignment, timeout) are flagged with sticky status bits.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in REQ without bus_ack before the access is aborted; must be >= 1.
- ERR_RDATA, 32'hDEADBEEF: read data returned on an aborted or misaligned read.

Ports:
- clk  in  1  core clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- core_memread  in  1  MEM-stage load present
- core_memwrite  in  1  MEM-stage store present
- core_addr  in  32  byte address (MEM-stage aluout)
- core_wdata  in  32  store data
- core_rdata  out  32  load data to MEM/WB register
- core_stall  out  1  freeze IF..MEM pipeline registers, bubble into WB
- bus_req  out  1  registered request
- bus_we  out  1  registered write enable, valid with bus_req
- bus_addr  out  32  registered word address, byte bits forced 0
- bus_wdata  out  32  registered write data
- bus_ack  in  1  slave completion, one cycle per transfer
- bus_rdata  in  32  read data, valid when bus_ack=1
- err_misalign  out  1  sticky: access with core_addr[1:0]!=0
- err_timeout  out  1  sticky: TIMEOUT_CYCLES expired
- err_clear  in  1  synchronous clear of both sticky flags

Behaviour:
- Reset values: core_rdata=0, core_stall=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, both err flags=0. FSM=IDLE, timeout counter=0.
- Access = core_memread | core_memwrite. If both are high, treat as a write.
- IDLE, no access: core_stall=0.
- IDLE, aligned access:
  - core_stall=1 combinationally.
  - Latch addr, wdata and we.
  - Next cycle bus_req=1, go to REQ.
- IDLE, misaligned access:
  - No bus transaction; core_stall=0.
  - core_rdata=ERR_RDATA; err_misalign set next edge.
  - Stores are dropped.
- REQ:
  - core_stall=1; bus outputs held stable.
  - Counter increments each cycle.
  - On bus_ack: latch bus_rdata (reads only) into core_rdata, drop bus_req the next cycle, go to DONE.
  - On counter==TIMEOUT_CYCLES-1 without ack: drop bus_req, set err_timeout, core_rdata=ERR_RDATA, go to DONE.
  - bus_ack and timeout on the same cycle: ack wins.
- DONE:
  - core_stall=0 for exactly one cycle; the pipeline advances and WB captures core_rdata.
  - Unconditionally return to IDLE; the still-present MEM-stage signals are not re-issued.
- Latency: an aligned access with ack on the first REQ cycle stalls 2 cycles (IDLE, REQ), then releases in DONE.
- bus_ack outside REQ is ignored.
- err_clear concurrent with a new error event: set wins.
- Reset mid-transaction: bus_req falls asynchronously, FSM goes to IDLE, and any latched data is discarded.

Optional Feature:
- Macro: DMEM_BRIDGE_WBUF_EN.
- With the macro defined, a one-entry posted write buffer is added:
  - An aligned store in IDLE with the buffer empty is captured without stalling (core_stall=0).
  - The buffer drains through REQ independently.
  - A store arriving while the buffer is full stalls until the drain completes.
  - A load arriving while the buffer is non-empty stalls until the drain completes, then issues; no forwarding.
  - A drain timeout sets err_timeout and empties the buffer.
- Without the macro, every store follows the blocking IDLE/REQ/DONE path.

Decomposition:
- Shared package (simparams.vh companion header): FSM state encodings IDLE/REQ/DONE, ERR_RDATA default, TIMEOUT_CYCLES default.
- One natural sub-module, dmem_wbuf: write-buffer entry plus valid flag, instantiated only under DMEM_BRIDGE_WBUF_EN.
- The timeout counter stays inline.

Test Plan:
- Load addr 0x100, bus_ack on 1st REQ cycle with bus_rdata=0x12345678 -> stall 2 cycles, DONE core_rdata=0x12345678, bus_we=0, bus_addr=0x100.
- Store addr 0x204 data 0xCAFEF00D, ack after 5 wait cycles -> bus_req held 6 cycles with bus_we=1, stable addr/data, stall released in DONE.
- Load addr 0x101 -> no bus_req, core_stall=0, core_rdata=0xDEADBEEF, err_misalign=1 until err_clear pulse.
- Load with bus_ack never asserted, TIMEOUT_CYCLES=16 -> bus_req drops after 16 REQ cycles, err_timeout=1, core_rdata=0xDEADBEEF.
- reset asserted on 3rd REQ cycle -> bus_req=0 same cycle, stall=0; after release the next load completes normally.
- With DMEM_BRIDGE_WBUF_EN: store then immediate load -> store no stall, load stalls until drain ack, then reads.
